// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction-fetch sequencer with branch/jump redirect.
// Define PC_FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets into a sticky fault state.
module pc_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t          state, state_n;
    logic            drop, drop_n;
    logic [XLEN-1:0] pc_n;
    logic [31:0]     inst_n;
    logic [XLEN-1:0] inst_pc_n;
    logic [XLEN-1:0] target_c;
    logic            misalign_c;

    // Low two target bits never reach the PC; instructions are word aligned.
    assign target_c      = redirect_target & ~XLEN'(3);
    assign imem_req_addr = pc;

`ifdef PC_FETCH_MISALIGN_CHECK_EN
    assign misalign_c = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
    assign misalign_c = 1'b0;
`endif

    // Next-state, next-PC and instruction capture.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        drop_n    = drop;
        inst_n    = inst;
        inst_pc_n = inst_pc;
        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                if (misalign_c) begin
                    state_n = ERROR;
                end else if (redirect_valid) begin
                    pc_n = target_c;
                    if (imem_req_ready) begin
                        state_n = WAIT;
                        drop_n  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (misalign_c) begin
                    state_n = ERROR;
                end else if (redirect_valid) begin
                    pc_n = target_c;
                    if (imem_rsp_valid) begin
                        state_n = REQ;
                        drop_n  = 1'b0;
                    end else begin
                        drop_n  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        inst_n    = imem_rsp_data;
                        inst_pc_n = pc;
                        pc_n      = pc_plus4;
                        state_n   = HOLD;
                    end
                end
            end
            HOLD: begin
                // A redirect squashes the held instruction even if decode is ready.
                if (misalign_c) begin
                    state_n = ERROR;
                end else if (redirect_valid) begin
                    pc_n    = target_c;
                    state_n = REQ;
                end else if (inst_ready) begin
                    state_n = REQ;
                end
            end
            ERROR:   state_n = ERROR;
            default: state_n = IDLE;
        endcase
    end

    // State, PC and registered outputs; valids are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            drop           <= 1'b0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            drop           <= drop_n;
            imem_req_valid <= (state_n == REQ);
            inst_valid     <= (state_n == HOLD);
            inst           <= inst_n;
            inst_pc        <= inst_pc_n;
        end
    end

`ifdef PC_FETCH_MISALIGN_CHECK_EN
    // ERROR is terminal until reset, so the flag is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else begin
            fault <= (state_n == ERROR);
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the single-issue RISC-V core. Holds the architectural PC, drives it into the PC+4 adder, and consumes the adder sum as the sequential next PC. Issues one instruction-memory request at a time and hands each fetched instruction to decode over a valid/ready handshake. Accepts branch/jump redirects from execute.

## Interface
- XLEN, 32, address/PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- pc  out  XLEN  current PC; drives adder a input (b = 4, cin = 0)
- pc_plus4  in  XLEN  adder sum s; must equal pc + 4 in the same cycle
- redirect_valid  in  1  execute requests a redirect this cycle
- redirect_target  in  XLEN  branch/jump target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  response valid; at most one per accepted request, never in the accept cycle
- imem_rsp_data  in  32  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction word
- inst_pc  out  XLEN  PC of inst
- fault  out  1  sticky misaligned-target fault

## Operation
- States: IDLE, REQ, WAIT, HOLD, ERROR.
- IDLE: entered on reset; unconditionally moves to REQ on the next clock edge.
- REQ: imem_req_valid = 1, imem_req_addr = pc. Handshake (valid & ready) -> WAIT.
- WAIT: on imem_rsp_valid with drop = 0: inst <= imem_rsp_data, inst_pc <= pc, pc <= pc_plus4, -> HOLD. With drop = 1: clear drop, discard data, -> REQ.
- HOLD: inst_valid = 1; inst/inst_pc stable. inst_valid & inst_ready -> REQ.
- Redirect (redirect_valid = 1) in REQ, WAIT or HOLD overrides sequential update: pc <= redirect_target.
  - REQ, no handshake: stay REQ; request address changes next cycle. Memory samples only on handshake.
  - REQ with same-cycle handshake: -> WAIT, drop <= 1.
  - WAIT, response not arriving: drop <= 1, stay WAIT.
  - WAIT, response arriving same cycle: discard response, -> REQ.
  - HOLD: held instruction squashed, inst_valid low next cycle, -> REQ. Also applies if inst_ready is high the same cycle; decode must not consume it.
- Redirect in IDLE is ignored.
- ERROR: see Configuration. No requests, inst_valid = 0, pc frozen. Exit only by reset.
- At most one request outstanding. PC wraps modulo 2^XLEN; pc_plus4 overflow is not flagged.

## Timing
- Reset values: pc = RESET_PC, state = IDLE, drop = 0, imem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0, fault = 0.
- Reset assertion mid-operation aborts immediately. An outstanding response after reset is not tracked; the memory is reset by the same rst_n.
- Outputs are registered or decoded from state only. No combinational path from any input to any output.
- Best case, with imem ready, response one cycle after accept and inst_ready = 1: REQ, WAIT, HOLD gives one instruction per 3 cycles.
- Redirect to first request at the new target: 1 cycle after the redirect edge, when in REQ or HOLD.

## Configuration
- PC_FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_target[1:0] != 2'b00, in REQ, WAIT or HOLD, moves to ERROR, sets fault = 1, and leaves pc unchanged.
  - An outstanding response is ignored.
- Undefined:
  - redirect_target[1:0] is forced to 2'b00 before loading pc.
  - fault is tied to 0 and the ERROR state is unreachable.

## Test plan
- Reset release, RESET_PC = 0x100, imem always ready, response 1 cycle after accept, inst_ready = 1 -> requests at 0x100, 0x104, 0x108, one per 3 cycles; inst_pc matches each.
- inst_ready held low 5 cycles in HOLD -> inst and inst_pc stable, no new request, pc = inst_pc + 4 throughout.
- Redirect to 0x200 in the same cycle as a REQ handshake for 0x104 -> response for 0x104 never presented; next request addr = 0x200.
- Redirect to 0x300 in HOLD while inst_ready = 1 -> held instruction squashed, inst_valid low next cycle, next request at 0x300.
- With PC_FETCH_MISALIGN_CHECK_EN: redirect to 0x202 -> fault = 1 next cycle, no further requests until rst_n low. Without the macro: next request at 0x200.
- rst_n asserted while in WAIT -> all outputs at reset values immediately (asynchronous); first request after release is at RESET_PC.
